// File: rtl/j1_boot_loader.sv
// Boot loader for the j1 core: receives a framed byte stream, writes 16-bit words
// into instruction RAM and releases the core's reset once the image checksum matches.
module j1_boot_loader #(
  parameter int          ADDRESS_WIDTH = 13,
  parameter logic [15:0] MAGIC         = 16'hA55A
) (
  input  logic                     clock,
  input  logic                     active_low_reset,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  input  logic                     restart,
  output logic                     ram_write_enable,
  output logic [ADDRESS_WIDTH-1:0] ram_write_address,
  output logic [15:0]              ram_write_data,
  output logic                     core_active_low_reset,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int          IW        = ADDRESS_WIDTH + 1;
  localparam logic [7:0]  MAGIC_HI  = MAGIC[15:8];
  localparam logic [7:0]  MAGIC_LO  = MAGIC[7:0];
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDRESS_WIDTH);

  typedef enum logic [3:0] {
    S_MAGIC0,
    S_MAGIC1,
    S_COUNT_LO,
    S_COUNT_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                   state_q, state_d;
  logic [7:0]               cnt_lo_q, cnt_lo_d;
  logic [15:0]              n_q, n_d;
  logic [7:0]               lo_q, lo_d;
  logic [7:0]               chk_q, chk_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] waddr_q, waddr_d;
  logic [15:0]              wdata_q, wdata_d;
  logic                     crst_q, crst_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic        accept;
  logic [15:0] count_w;
  logic        last_word;

  // A restart in the same cycle withdraws ready so the byte is visibly not taken.
  assign byte_ready = !restart && (state_q != S_DONE) && (state_q != S_ERROR);
  assign accept     = byte_valid && byte_ready;
  assign count_w    = {byte_data, cnt_lo_q};
  assign last_word  = (idx_q == IW'(n_q - 16'd1));

  always_comb begin
    state_d  = state_q;
    cnt_lo_d = cnt_lo_q;
    n_d      = n_q;
    lo_d     = lo_q;
    chk_d    = chk_q;
    idx_d    = idx_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    crst_d   = crst_q;
    done_d   = done_q;
    err_d    = err_q;
    if (restart) begin
      state_d = S_MAGIC0;
      crst_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else if (accept) begin
      unique case (state_q)
        S_MAGIC0: begin
          if (byte_data == MAGIC_HI) state_d = S_MAGIC1;
        end
        S_MAGIC1: begin
          // A repeated first magic byte may itself start the real header.
          if (byte_data == MAGIC_LO)      state_d = S_COUNT_LO;
          else if (byte_data != MAGIC_HI) state_d = S_MAGIC0;
        end
        S_COUNT_LO: begin
          cnt_lo_d = byte_data;
          state_d  = S_COUNT_HI;
        end
        S_COUNT_HI: begin
          n_d   = count_w;
          chk_d = 8'h00;
          idx_d = '0;
          if (count_w == 16'd0 || {1'b0, count_w} > MAX_WORDS) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          lo_d    = byte_data;
          chk_d   = chk_q ^ byte_data;
          state_d = S_DATA_HI;
        end
        S_DATA_HI: begin
          chk_d   = chk_q ^ byte_data;
          we_d    = 1'b1;
          waddr_d = idx_q[ADDRESS_WIDTH-1:0];
          wdata_d = {byte_data, lo_q};
          idx_d   = idx_q + IW'(1);
          state_d = last_word ? S_CHECK : S_DATA_LO;
        end
        S_CHECK: begin
          if (byte_data == chk_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            crst_d  = 1'b1;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      state_q <= S_MAGIC0;
      chk_q   <= 8'h00;
      idx_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 16'h0000;
      crst_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chk_q   <= chk_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      crst_q  <= crst_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Frame scratch registers are always rewritten before use.
  always_ff @(posedge clock) begin
    cnt_lo_q <= cnt_lo_d;
    n_q      <= n_d;
    lo_q     <= lo_d;
  end

  assign ram_write_enable      = we_q;
  assign ram_write_address     = waddr_q;
  assign ram_write_data        = wdata_q;
  assign core_active_low_reset = crst_q;
  assign done                  = done_q;
  assign error                 = err_q;
  assign busy                  = (state_q != S_MAGIC0) && (state_q != S_DONE) &&
                                 (state_q != S_ERROR);

endmodule

// File: tb/tb_j1_boot_loader.sv
// Bench for j1_boot_loader: cycle table, hand-written frames and random frames
// checked against a frame-parsing reference model.
module tb_j1_boot_loader;
  localparam int AW = 13;

  typedef logic [7:0] byteq_t[$];
  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } ew_t;
  typedef ew_t ewq_t[$];
  typedef struct {
    logic          rs;
    logic          v;
    logic [7:0]    d;
    logic          rdy;
    logic          we;
    logic [AW-1:0] a;
    logic [15:0]   wd;
    logic          bsy;
    logic          dn;
    logic          er;
    logic          crst;
  } vec_t;

  logic          clock = 1'b0;
  logic          active_low_reset;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          restart;
  logic          ram_write_enable;
  logic [AW-1:0] ram_write_address;
  logic [15:0]   ram_write_data;
  logic          core_active_low_reset;
  logic          busy;
  logic          done;
  logic          error;

  int nvec = 0;
  int nmis = 0;
  ew_t wlog[$];

  j1_boot_loader #(.ADDRESS_WIDTH(AW), .MAGIC(16'hA55A)) dut (
    .clock                 (clock),
    .active_low_reset      (active_low_reset),
    .byte_valid            (byte_valid),
    .byte_data             (byte_data),
    .byte_ready            (byte_ready),
    .restart               (restart),
    .ram_write_enable      (ram_write_enable),
    .ram_write_address     (ram_write_address),
    .ram_write_data        (ram_write_data),
    .core_active_low_reset (core_active_low_reset),
    .busy                  (busy),
    .done                  (done),
    .error                 (error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (ram_write_enable === 1'b1) wlog.push_back('{ram_write_address, ram_write_data});
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: a frame starts at the first adjacent A5,5A pair; everything after the
  // frame's final byte is refused.
  function automatic void model(input byteq_t b, output ewq_t w, output bit dn,
                                output bit er, output int used);
    int i;
    int n;
    logic [7:0] cs;
    logic [7:0] lo;
    logic [7:0] hi;
    w = {};
    dn = 1'b0;
    er = 1'b0;
    used = b.size();
    i = 0;
    while (i + 1 < b.size() && !(b[i] == 8'hA5 && b[i+1] == 8'h5A)) i++;
    if (i + 3 >= b.size()) return;
    n = int'({b[i+3], b[i+2]});
    if (n == 0 || n > (1 << AW)) begin
      er = 1'b1;
      used = i + 4;
      return;
    end
    if (i + 4 + 2 * n >= b.size()) return;
    cs = 8'h00;
    for (int k = 0; k < n; k++) begin
      lo = b[i + 4 + 2 * k];
      hi = b[i + 5 + 2 * k];
      cs = cs ^ lo ^ hi;
      w.push_back('{AW'(k), {hi, lo}});
    end
    if (b[i + 4 + 2 * n] == cs) dn = 1'b1;
    else er = 1'b1;
    used = i + 5 + 2 * n;
  endfunction

  // Called and returning at a falling edge. Stops offering once ready drops.
  task automatic send_bytes(input byteq_t b, input int gap_pct, output int nacc);
    nacc = 0;
    foreach (b[i]) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        byte_valid = 1'b0;
        @(negedge clock);
      end
      byte_valid = 1'b1;
      byte_data  = b[i];
      #1;
      if (byte_ready !== 1'b1) begin
        byte_valid = 1'b0;
        break;
      end
      @(negedge clock);
      nacc++;
      byte_valid = 1'b0;
    end
    byte_valid = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_result(input string nm, input ewq_t ew, input bit edn, input bit eer,
                              input int eused, input int nacc);
    repeat (2) @(negedge clock);
    chk({nm, " accepted"}, 64'(nacc), 64'(eused));
    chk({nm, " writes"}, 64'(wlog.size()), 64'(ew.size()));
    for (int k = 0; k < ew.size() && k < wlog.size(); k++)
      chk({nm, " write"}, {wlog[k].addr, wlog[k].data}, {ew[k].addr, ew[k].data});
    chk({nm, " status"}, {done, error, core_active_low_reset, busy, byte_ready},
        {edn, eer, edn, !(edn || eer), !(edn || eer)});
  endtask

  vec_t tbl[13];

  initial begin
    byteq_t q;
    ewq_t   ew;
    bit     edn;
    bit     eer;
    int     used;
    int     nacc;

    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    byteq_t q;
    ewq_t   ew;
    bit     edn;
    bit     eer;
    int     used;
    int     nacc;
    int     n;
    logic [7:0] cs;
    logic [7:0] bb;

    tbl[0]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 13'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 13'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 13'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 13'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 13'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 13'd0, 16'h8005, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 13'd0, 16'h8005, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 13'd0, 16'h8005, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h60, 1'b1, 1'b1, 13'd1, 16'h6000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'hE5, 1'b0, 1'b0, 13'd1, 16'h6000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 13'd1, 16'h6000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 13'd1, 16'h6000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 13'd1, 16'h6000, 1'b0, 1'b0, 1'b0, 1'b0};

    active_low_reset = 1'b0;
    restart    = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    #12;
    chk("reset values",
        {byte_ready, ram_write_enable, ram_write_address, ram_write_data,
         core_active_low_reset, busy, done, error},
        {1'b1, 1'b0, 13'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clock);
    active_low_reset = 1'b1;
    @(negedge clock);

    // Cycle-exact frame with a valid gap inside a word, then back-pressure and restart.
    foreach (tbl[i]) begin
      restart    = tbl[i].rs;
      byte_valid = tbl[i].v;
      byte_data  = tbl[i].d;
      @(posedge clock);
      #1;
      chk($sformatf("table row %0d", i),
          {byte_ready, ram_write_enable, ram_write_address, ram_write_data,
           busy, done, error, core_active_low_reset},
          {tbl[i].rdy, tbl[i].we, tbl[i].a, tbl[i].wd,
           tbl[i].bsy, tbl[i].dn, tbl[i].er, tbl[i].crst});
      @(negedge clock);
    end
    restart = 1'b0;
    byte_valid = 1'b0;

    // Bad checksum, then restart back to header search.
    wlog.delete();
    q = '{8'hA5, 8'h5A, 8'h02, 8'h00, 8'h05, 8'h80, 8'h00, 8'h60, 8'h00, 8'h11};
    ew = {};
    ew.push_back('{13'd0, 16'h8005});
    ew.push_back('{13'd1, 16'h6000});
    send_bytes(q, 0, nacc);
    check_result("bad checksum", ew, 1'b0, 1'b1, 9, nacc);
    pulse_restart();
    chk("restart clears error", {error, done, core_active_low_reset, busy, byte_ready},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    q = '{8'hA5};
    send_bytes(q, 0, nacc);
    chk("restart back in header search", {busy, nacc[3:0]}, {1'b1, 4'd1});
    pulse_restart();

    // Header resync through noise and a repeated A5.
    wlog.delete();
    q = '{8'h11, 8'hA5, 8'hA5, 8'h5A, 8'h01, 8'h00, 8'h34, 8'h12, 8'h26};
    ew = {};
    ew.push_back('{13'd0, 16'h1234});
    send_bytes(q, 0, nacc);
    check_result("resync", ew, 1'b1, 1'b0, 9, nacc);
    pulse_restart();

    // Count errors: zero words and one word beyond the RAM size.
    wlog.delete();
    q = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h77};
    ew = {};
    send_bytes(q, 0, nacc);
    check_result("count zero", ew, 1'b0, 1'b1, 4, nacc);
    pulse_restart();
    wlog.delete();
    q = '{8'hA5, 8'h5A, 8'h01, 8'h20, 8'h77};
    send_bytes(q, 0, nacc);
    check_result("count 8193", ew, 1'b0, 1'b1, 4, nacc);
    pulse_restart();

    // Asynchronous reset mid-frame, then replay of the full frame.
    wlog.delete();
    q = '{8'hA5, 8'h5A, 8'h02, 8'h00, 8'h05};
    send_bytes(q, 0, nacc);
    #2;
    active_low_reset = 1'b0;
    #1;
    chk("async reset mid-frame",
        {byte_ready, ram_write_enable, ram_write_address, ram_write_data,
         core_active_low_reset, busy, done, error},
        {1'b1, 1'b0, 13'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clock);
    active_low_reset = 1'b1;
    @(negedge clock);
    wlog.delete();
    q = '{8'hA5, 8'h5A, 8'h02, 8'h00, 8'h05, 8'h80, 8'h00, 8'h60, 8'hE5};
    ew = {};
    ew.push_back('{13'd0, 16'h8005});
    ew.push_back('{13'd1, 16'h6000});
    send_bytes(q, 0, nacc);
    check_result("replay after reset", ew, 1'b1, 1'b0, 9, nacc);
    pulse_restart();

    // Random frames: noise prefix, random words, occasional bad checksum or count.
    for (int t = 0; t < 30; t++) begin
      wlog.delete();
      q = {};
      for (int g = 0, ng = $urandom_range(3); g < ng; g++) begin
        bb = 8'($urandom_range(255));
        if (bb == 8'h5A) bb = 8'h11;
        q.push_back(bb);
      end
      q.push_back(8'hA5);
      q.push_back(8'h5A);
      if (t % 7 == 3) begin
        n = (t % 2 == 0) ? 0 : 16'h2001 + $urandom_range(1000);
        q.push_back(n[7:0]);
        q.push_back(n[15:8]);
      end else begin
        n = $urandom_range(1, 6);
        q.push_back(n[7:0]);
        q.push_back(n[15:8]);
        cs = 8'h00;
        for (int k = 0; k < 2 * n; k++) begin
          bb = 8'($urandom_range(255));
          cs = cs ^ bb;
          q.push_back(bb);
        end
        if ($urandom_range(3) == 0) cs = cs ^ (8'h01 << $urandom_range(7));
        q.push_back(cs);
      end
      for (int k = 0, nt = $urandom_range(2); k < nt; k++) q.push_back(8'($urandom_range(255)));
      model(q, ew, edn, eer, used);
      send_bytes(q, (t % 3 == 0) ? 0 : 30, nacc);
      check_result($sformatf("random %0d", t), ew, edn, eer, used, nacc);
      pulse_restart();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/j1_boot_loader.md
Name: j1_boot_loader

Overview:
- Sits upstream of the j1 core. Receives a byte stream (from a UART or host link) on a valid/ready interface.
- Assembles little-endian 16-bit instruction words and writes them into the instruction RAM that feeds the core's instruction port.
- Holds the core in reset until a complete, checksum-verified image has been loaded, then releases it.

Parameters:
ADDRESS_WIDTH, 13, width of instruction RAM word address (matches core instruction_address)
MAGIC, 16'hA55A, frame header; first byte 8'hA5, second byte 8'h5A

Ports:
clock  input  1  system clock
active_low_reset  input  1  asynchronous, active-low reset
byte_valid  input  1  upstream byte present
byte_data  input  8  upstream byte
byte_ready  output  1  loader accepts byte this cycle (transfer = valid & ready)
restart  input  1  synchronous pulse: abandon state, re-enter header search, re-assert core reset
ram_write_enable  output  1  one-cycle write strobe to instruction RAM
ram_write_address  output  ADDRESS_WIDTH  word address of write
ram_write_data  output  16  instruction word {hi, lo}
core_active_low_reset  output  1  reset to j1 core; 0 = held
busy  output  1  frame in progress (past MAGIC0)
done  output  1  image loaded and verified
error  output  1  frame rejected (bad count or checksum)

Behaviour:
- Reset is asynchronous, active-low; clock and reset named clock / active_low_reset.
- Reset values: byte_ready=1, ram_write_enable=0, ram_write_address=0, ram_write_data=0, core_active_low_reset=0, busy=0, done=0, error=0, state=MAGIC0, checksum=0, word index=0.
- Frame format: A5, 5A, COUNT_LO, COUNT_HI, then 2*N data bytes (lo then hi per word), then 1 checksum byte.
  - N = {COUNT_HI, COUNT_LO}.
  - Checksum byte = XOR of all 2*N data bytes.
- States: MAGIC0, MAGIC1, COUNT_LO, COUNT_HI, DATA_LO, DATA_HI, CHECK, DONE, ERROR. Transitions occur only on accepted bytes, except restart.
- MAGIC0:
  - 8'hA5 -> MAGIC1.
  - Any other byte -> stay.
- MAGIC1:
  - 8'h5A -> COUNT_LO.
  - 8'hA5 -> stay.
  - Any other byte -> MAGIC0.
- COUNT_LO -> COUNT_HI, latching the low count byte.
- COUNT_HI: clears checksum and word index, then:
  - N==0 or N > 2**ADDRESS_WIDTH -> ERROR.
  - Otherwise -> DATA_LO.
- DATA_LO: latch lo byte, XOR into checksum -> DATA_HI.
- DATA_HI: XOR into checksum. On the next clock edge (registered, latency 1 from acceptance):
  - ram_write_enable=1.
  - ram_write_address = word index.
  - ram_write_data = {hi, lo}.
  - The strobe lasts exactly one cycle; word index increments.
  - Last word (index == N-1) -> CHECK, else -> DATA_LO.
- CHECK:
  - Byte == checksum -> DONE. On that same edge: done=1, core_active_low_reset=1.
  - Byte != checksum -> ERROR, error=1.
- DONE and ERROR: byte_ready=0 (stream back-pressured); state held until restart or reset.
- byte_ready=1 in all other states. The loader never stalls mid-frame; throughput is 1 byte/cycle.
- restart (any state, highest priority over a same-cycle byte; that byte is not consumed):
  - Next edge: state=MAGIC0, core_active_low_reset=0, done=0, error=0, ram_write_enable=0.
  - Already-written RAM contents are untouched.
- busy=1 in every state except MAGIC0, DONE and ERROR.
- Word index width is ADDRESS_WIDTH+1 so N = 2**ADDRESS_WIDTH is representable. Writes never wrap past 2**ADDRESS_WIDTH-1.
- Reset mid-frame: everything returns to reset values immediately. A partial image may remain in RAM; the core stays held.
- The core sees its reset released only after the last RAM write has completed: the last write strobe precedes the checksum byte by at least one cycle.

Test Plan:
- Load N=2, words 16'h8005, 16'h6000: bytes A5 5A 02 00 05 80 00 60 E5.
  - Required: writes (addr 0, 8005) then (addr 1, 6000), each a 1-cycle strobe one cycle after the hi byte.
  - Required: done=1 and core_active_low_reset=1 on the edge accepting E5; byte_ready=0 afterwards.
- Same frame with checksum byte 00 -> error=1, core_active_low_reset stays 0, byte_ready=0; then restart pulse -> error=0, state MAGIC0, byte_ready=1.
- Header resync: bytes 11 A5 A5 5A 01 00 34 12 26 -> single write (addr 0, 1234), done=1.
- Count errors: A5 5A 00 00 -> error=1 with no writes. A5 5A 01 20 (N=8193, ADDRESS_WIDTH=13) -> error=1.
- Back-to-back bytes with byte_valid held high for the whole frame -> all bytes accepted consecutively with no dropped or duplicated writes. A byte_valid gap mid-word -> no spurious strobe.
- Assert active_low_reset low after the 5th byte of the first frame -> all outputs at reset values asynchronously. Replay the full frame -> normal completion.
